// File: rtl/operand_fetch_unit.sv
// Operand fetch sequencer: reads the W matrix and then the X matrix row by row through a
// single-outstanding, fixed-latency memory port, and presents each assembled row downstream.
module operand_fetch_unit #(
  parameter int unsigned N              = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BANKING_FACTOR = 1,
  parameter int unsigned ADDRESS_WIDTH  = 13,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_W = 13'h0000,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_X = 13'h1000,
  parameter int unsigned MEM_LATENCY    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 mem_read_en,
  output logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
  output logic [N*DATA_WIDTH-1:0]              out_row,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_is_x,
  output logic [$clog2(N)-1:0]                 out_row_idx,
  output logic                                 out_last
);

  localparam int unsigned REQS  = N / BANKING_FACTOR;
  localparam int unsigned KW    = (REQS > 1) ? $clog2(REQS) : 1;
  localparam int unsigned RW    = $clog2(N);
  localparam int unsigned WCW   = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [WCW-1:0]             wait_q, wait_d;
  logic [KW-1:0]              req_q, req_d;

  logic                       busy_d, done_d, read_en_d, valid_d, is_x_d, last_d;
  logic [ADDRESS_WIDTH-1:0]   addr_d;
  logic [N*DATA_WIDTH-1:0]    row_d;
  logic [RW-1:0]              idx_d;
  logic                       last_row;

  // Byte address of request k of row r in the selected matrix, wrapping at the address width.
  function automatic logic [ADDRESS_WIDTH-1:0] req_addr(input logic          is_x,
                                                        input logic [RW-1:0] row,
                                                        input logic [KW-1:0] k);
    logic [31:0] off;
    off = (32'(row) * N + 32'(k) * BANKING_FACTOR) * BYTES;
    return (is_x ? BASE_ADDR_X : BASE_ADDR_W) + ADDRESS_WIDTH'(off);
  endfunction

  assign last_row = out_is_x && (out_row_idx == RW'(N - 1));

  // State and output registers; out_is_x / out_row_idx double as the matrix and row counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      req_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_req_addr <= '0;
      out_row      <= '0;
      out_valid    <= 1'b0;
      out_is_x     <= 1'b0;
      out_row_idx  <= '0;
      out_last     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      req_q        <= req_d;
      busy         <= busy_d;
      done         <= done_d;
      mem_read_en  <= read_en_d;
      mem_req_addr <= addr_d;
      out_row      <= row_d;
      out_valid    <= valid_d;
      out_is_x     <= is_x_d;
      out_row_idx  <= idx_d;
      out_last     <= last_d;
    end
  end

  // Next-state and next-output decode; registered outputs reflect the state being entered.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    req_d     = req_q;
    read_en_d = 1'b0;
    done_d    = 1'b0;
    addr_d    = mem_req_addr;
    row_d     = out_row;
    valid_d   = out_valid;
    is_x_d    = out_is_x;
    idx_d     = out_row_idx;
    last_d    = out_last;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          wait_d    = '0;
          req_d     = '0;
          is_x_d    = 1'b0;
          idx_d     = '0;
          read_en_d = 1'b1;
          addr_d    = req_addr(1'b0, '0, '0);
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end

      S_WAIT: begin
        if (wait_q == WCW'(MEM_LATENCY)) begin
          // Response banks land in consecutive row elements; the rest of the row is kept.
          for (int unsigned b = 0; b < BANKING_FACTOR; b++) begin
            row_d[(32'(req_q) * BANKING_FACTOR + b) * DATA_WIDTH +: DATA_WIDTH] =
              mem_resp_data[b * DATA_WIDTH +: DATA_WIDTH];
          end
          wait_d = '0;
          if (req_q == KW'(REQS - 1)) begin
            req_d   = '0;
            state_d = S_PRESENT;
            valid_d = 1'b1;
            last_d  = last_row;
          end else begin
            req_d     = req_q + KW'(1);
            state_d   = S_ISSUE;
            read_en_d = 1'b1;
            addr_d    = req_addr(out_is_x, out_row_idx, req_q + KW'(1));
          end
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end

      S_PRESENT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_row) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            is_x_d  = 1'b0;
            idx_d   = '0;
          end else begin
            if (out_row_idx == RW'(N - 1)) begin
              is_x_d = 1'b1;
              idx_d  = '0;
            end else begin
              idx_d = out_row_idx + RW'(1);
            end
            state_d   = S_ISSUE;
            read_en_d = 1'b1;
            addr_d    = req_addr(is_x_d, idx_d, '0);
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit: default config plus a BANKING_FACTOR=2 instance,
// each fed by a fixed-latency memory model with hand-derived contents.
module tb_operand_fetch_unit;

  logic clk = 1'b0;
  logic rst, start, start_b, out_ready;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Instance A: defaults
  logic        busy_a, done_a, rd_a, valid_a, isx_a, last_a;
  logic [12:0] addr_a;
  logic [15:0] resp_a = '0;
  logic [63:0] row_a;
  logic [1:0]  idx_a;

  // Instance B: two banks per response
  logic        busy_b, done_b, rd_b, valid_b, isx_b, last_b;
  logic [12:0] addr_b;
  logic [31:0] resp_b = '0;
  logic [63:0] row_b;
  logic [1:0]  idx_b;

  operand_fetch_unit #(.N(4), .DATA_WIDTH(16), .BANKING_FACTOR(1), .ADDRESS_WIDTH(13),
                       .BASE_ADDR_W(13'h0000), .BASE_ADDR_X(13'h1000), .MEM_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
    .mem_read_en(rd_a), .mem_req_addr(addr_a), .mem_resp_data(resp_a),
    .out_row(row_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_is_x(isx_a), .out_row_idx(idx_a), .out_last(last_a));

  operand_fetch_unit #(.N(4), .DATA_WIDTH(16), .BANKING_FACTOR(2), .ADDRESS_WIDTH(13),
                       .BASE_ADDR_W(13'h0000), .BASE_ADDR_X(13'h1000), .MEM_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_read_en(rd_b), .mem_req_addr(addr_b), .mem_resp_data(resp_b),
    .out_row(row_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_is_x(isx_b), .out_row_idx(idx_b), .out_last(last_b));

  // W(r,c) = c<<8, X(r,c) = (c<<8)+1; rows are 8 bytes so column = addr[2:1], matrix = addr[12]
  function automatic logic [15:0] mem_word(input logic [12:0] a);
    return {6'b0, a[2:1], 7'b0, a[12]};
  endfunction

  // Memory models: response register updates two edges after the request is captured
  logic        pa1 = 1'b0, pa2 = 1'b0, pb1 = 1'b0, pb2 = 1'b0;
  logic [12:0] aa1 = '0, aa2 = '0, ab1 = '0, ab2 = '0;
  always @(posedge clk) begin
    pa1 <= rd_a; aa1 <= addr_a; pa2 <= pa1; aa2 <= aa1;
    if (pa2) resp_a <= mem_word(aa2);
    pb1 <= rd_b; ab1 <= addr_b; pb2 <= pb1; ab2 <= ab1;
    if (pb2) resp_b <= {mem_word(ab2 + 13'd2), mem_word(ab2)};
  end

  localparam logic [63:0] W_ROW = 64'h0300_0200_0100_0000;
  localparam logic [63:0] X_ROW = 64'h0301_0201_0101_0001;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_busy"},  64'(busy_a),  64'd0);
    check({tag, "_done"},  64'(done_a),  64'd0);
    check({tag, "_rd"},    64'(rd_a),    64'd0);
    check({tag, "_addr"},  64'(addr_a),  64'd0);
    check({tag, "_row"},   row_a,        64'd0);
    check({tag, "_valid"}, 64'(valid_a), 64'd0);
    check({tag, "_isx"},   64'(isx_a),   64'd0);
    check({tag, "_idx"},   64'(idx_a),   64'd0);
    check({tag, "_last"},  64'(last_a),  64'd0);
  endtask

  // Full W+X fetch on instance A. stall: ready-low cycles on W row 1; glitch_t: cycle of an
  // extra start pulse; abort_t: cycle at which reset is asserted mid-fetch (0 = none).
  task automatic run_a(input int stall, input int glitch_t, input int abort_t);
    int t, rows, reqs, last_req_t, hs1_t, stall_left, mat, rr, k;
    logic [63:0] held_row;
    logic [3:0]  held_tags;
    bit fin;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 1; rows = 0; reqs = 0; last_req_t = -100; hs1_t = -1; stall_left = stall; fin = 0;
    held_row = '0; held_tags = '0;
    while (!fin && t < 400) begin
      start = (t == glitch_t);
      if (abort_t > 0 && t == abort_t) begin
        check("abort_rows_seen", 64'(rows), 64'd2);
        #2 rst = 1'b1;
        #1 check_zero_a("async_rst");
        repeat (3) begin
          @(posedge clk); #1;
          check("rst_no_done", 64'(done_a), 64'd0);
        end
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (rd_a) begin
        mat = reqs / 16; rr = (reqs % 16) / 4; k = reqs % 4;
        check("req_addr", 64'(addr_a), 64'((mat != 0 ? 13'h1000 : 13'h0) + 13'(rr * 8 + k * 2)));
        check("req_gap_ge4", 64'(t - last_req_t >= 4), 64'd1);
        if (reqs == 0) check("first_issue_t", 64'(t), 64'd1);
        else if (k != 0) check("req_gap_row", 64'(t - last_req_t), 64'd4);
        if (reqs == 8 && hs1_t >= 0) check("resume_t", 64'(t), 64'(hs1_t + 1));
        reqs++;
        last_req_t = t;
      end
      if (valid_a) begin
        if (!isx_a && idx_a == 2'd1 && stall_left > 0) begin
          if (stall_left == stall) begin
            held_row = row_a; held_tags = {isx_a, idx_a, last_a};
          end else begin
            check("stall_row", row_a, held_row);
            check("stall_tags", 64'({isx_a, idx_a, last_a}), 64'(held_tags));
          end
          check("stall_no_req", 64'(rd_a), 64'd0);
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          check("row_data", row_a, rows < 4 ? W_ROW : X_ROW);
          check("row_idx", 64'(idx_a), 64'(rows % 4));
          check("row_isx", 64'(isx_a), 64'(rows / 4));
          check("row_last", 64'(last_a), 64'(rows == 7));
          check("row_hs_t", 64'(t), 64'(17 + 17 * rows + (rows >= 1 ? stall : 0)));
          if (rows == 1) hs1_t = t;
          rows++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done_a) begin
        check("done_t", 64'(t), 64'(137 + stall));
        check("done_rows", 64'(rows), 64'd8);
        check("done_reqs", 64'(reqs), 64'd32);
        fin = 1;
      end
      @(posedge clk); #1;
      t++;
    end
    if (!fin) check("done_timeout", 64'd0, 64'd1);
    check("busy_fall", 64'(busy_a), 64'd0);
    check("done_pulse", 64'(done_a), 64'd0);
  endtask

  // Instance B: two requests per row with 4-byte stride, 9-cycle row period
  task automatic run_b();
    int t, rows, reqs;
    bit fin;
    out_ready = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    t = 1; rows = 0; reqs = 0; fin = 0;
    while (!fin && t < 200) begin
      if (rd_b) begin
        check("b_req_addr", 64'(addr_b),
              64'((reqs >= 8 ? 13'h1000 : 13'h0) + 13'(((reqs % 8) / 2) * 8 + (reqs % 2) * 4)));
        reqs++;
      end
      if (valid_b) begin
        check("b_row_data", row_b, rows < 4 ? W_ROW : X_ROW);
        check("b_row_idx", 64'(idx_b), 64'(rows % 4));
        check("b_row_isx", 64'(isx_b), 64'(rows / 4));
        check("b_row_last", 64'(last_b), 64'(rows == 7));
        check("b_row_t", 64'(t), 64'(9 + 9 * rows));
        rows++;
      end
      if (done_b) begin
        check("b_done_t", 64'(t), 64'd73);
        check("b_reqs", 64'(reqs), 64'd16);
        fin = 1;
      end
      @(posedge clk); #1;
      t++;
    end
    if (!fin) check("b_done_timeout", 64'd0, 64'd1);
    check("b_busy_fall", 64'(busy_b), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_b = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_a("reset");
    check("reset_b_row", row_b, 64'd0);
    check("reset_b_busy", 64'(busy_b), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_a(0, 0, 0);     // nominal W then X fetch
    run_a(10, 0, 0);    // backpressure on W row 1
    run_a(0, 5, 37);    // stray start while busy, then reset in W row 2 WAIT
    check_zero_a("post_abort");
    run_a(0, 0, 0);     // restart reproduces the nominal run
    repeat (2) @(posedge clk);
    #1;
    run_b();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Sequencer between the mock/real operand memory and the systolic-array loader. On `start`, it reads the N×N weight matrix W and then the N×N activation matrix X from memory using single-outstanding, fixed-latency read requests. It assembles each matrix row into an N-element vector and hands rows downstream over a valid/ready handshake, W rows first, then X rows.

## Interface
- `N`, 4: matrix dimension; rows and columns per matrix.
- `DATA_WIDTH`, 16: element width in bits; must be a multiple of 8.
- `BANKING_FACTOR`, 1: elements returned per memory response; N must be divisible by it.
- `ADDRESS_WIDTH`, 13: byte-address width.
- `BASE_ADDR_W`, 13'h0000: byte base of W, row-major.
- `BASE_ADDR_X`, 13'h1000: byte base of X, row-major.
- `MEM_LATENCY`, 2: memory latency in clock edges from request capture to response register update.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a fetch of W then X; honoured only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse after the last X row handshakes.
- `mem_read_en` out 1: read request strobe, held for exactly one cycle per request.
- `mem_req_addr` out ADDRESS_WIDTH: byte address of the request.
- `mem_resp_data` in BANKING_FACTOR*DATA_WIDTH: read data; bank b is in `[b*DATA_WIDTH +: DATA_WIDTH]`.
- `out_row` out N*DATA_WIDTH: assembled row; element c is in `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `out_valid` out 1: `out_row` and its tags are valid.
- `out_ready` in 1: downstream accepts the row.
- `out_is_x` out 1: 0 = W row, 1 = X row.
- `out_row_idx` out $clog2(N): row index within the current matrix.
- `out_last` out 1: high with the final X row.

## Operation
- States and transitions:
  - IDLE: goes to ISSUE when `start` is sampled high.
  - ISSUE: lasts 1 cycle, drives `mem_read_en`=1, then goes to WAIT.
  - WAIT: counts the wait counter from 0 up to MEM_LATENCY. When the counter reaches MEM_LATENCY, it captures the response. It then returns to ISSUE if words remain in the row, or goes to PRESENT if the row is complete.
  - PRESENT: drives `out_valid`=1. On handshake, it goes to DONE if this was the last row, otherwise to ISSUE.
  - DONE: lasts 1 cycle with `done`=1, then goes to IDLE.
- Request k of row r in matrix M (M is W or X) addresses BASE_M + (r*N + k*BANKING_FACTOR)*(DATA_WIDTH/8).
  - Each row needs N/BANKING_FACTOR requests.
  - Address arithmetic is modulo 2^ADDRESS_WIDTH.
- Response bank b of request k is written to row element k*BANKING_FACTOR+b. Other elements are unchanged.
- Sequence order: W rows 0..N-1 with `out_is_x`=0, then X rows 0..N-1 with `out_is_x`=1. `out_last`=1 only on X row N-1.
- There is never more than one request outstanding. No request is issued while in PRESENT, so downstream backpressure stalls fetching.
- While `out_valid`=1 and `out_ready`=0, `out_row`, `out_is_x`, `out_row_idx` and `out_last` are held stable.
- `start` is ignored outside IDLE.
- `out_ready` is ignored outside PRESENT.
- `mem_resp_data` is sampled only on the capture edge.

## Timing
- All outputs are registered.
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `mem_read_en`, `out_valid`, `out_is_x` and `out_last` are 0.
  - `mem_req_addr`, `out_row` and `out_row_idx` are 0.
  - Internal counters are 0.
- `rst` asserted mid-operation aborts immediately:
  - All state returns to reset values.
  - No `done` pulse is produced.
  - Any in-flight memory response is discarded.
- The start edge is E_s. The first ISSUE occurs in cycle E_s+1.
- Each request occupies MEM_LATENCY+2 cycles: 1 ISSUE cycle plus MEM_LATENCY+1 WAIT cycles. This guarantees the memory's pending flag has cleared before the next request.
- Row fetch time is (N/BANKING_FACTOR)*(MEM_LATENCY+2) cycles. PRESENT follows in the next cycle.
- With `out_ready` held high, the row period is fetch time + 1 cycle.
- With defaults:
  - Row period is 17 cycles.
  - The first `out_valid` is in cycle E_s+17.
  - The last row is presented in cycle E_s+136.
  - `done` is high in cycle E_s+137.
  - `busy` falls in cycle E_s+138.
- `mem_req_addr` keeps its last value outside ISSUE.

## Test plan
- Memory model returns W element (r,c) = c<<8 and X element (r,c) = (c<<8)+1, with `out_ready`=1. Pulse `start`:
  - Expect 8 rows: W rows = {0x0000,0x0100,0x0200,0x0300} and X rows = {0x0001,0x0101,0x0201,0x0301}.
  - Expect `out_row_idx` to step 0..3 twice, with `out_last` high only on the 8th row.
  - Expect `done` in cycle E_s+137.
- Request trace:
  - `mem_read_en` pulses every 4 cycles.
  - Addresses are 0x000,0x002,…,0x01E, then 0x1000,0x1002,…,0x101E.
  - There are never two requests within 4 cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles on W row 1.
  - `out_row` and tags stay stable.
  - No `mem_read_en` is issued.
  - The fetch resumes 1 cycle after the handshake, and `done` is delayed by exactly 10 cycles.
- BANKING_FACTOR=2, N=4:
  - Expect 2 requests per row, with address stride 4 bytes.
  - Row period is 9 cycles and the data is the same as in scenario 1.
- Pulse `start` while `busy`=1: the sequence is unaffected. Assert `rst` during W row 2 WAIT:
  - All outputs go to 0 asynchronously and there is no `done` pulse.
  - A new `start` reproduces scenario 1 exactly.
